// File: rtl/spi_master.sv
// Byte-stream SPI master (mode 0, MSB first, active-low SSEL); first SCK rise CLK_DIV+1 clk after accept, rx pulse one clk after the last fall.
// Backpressure: tx_ready only in IDLE, WAIT and the bit-0 high phase of a non-last byte; at most one byte is held ahead of the shifter.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP} state_t;

  localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic [6:0] tx_sh, tx_sh_d;
  logic [7:0] rx_sh, rx_sh_d;
  logic       last_flag, last_flag_d;
  logic       nxt_vld, nxt_vld_d;
  logic [7:0] nxt_data, nxt_data_d;
  logic       nxt_last, nxt_last_d;
  logic       sck_d, mosi_d, ssel_d;
  logic       done, done_d;
  logic       miso_meta, miso_s;
  logic       accept, cnt_end, have_next;
  logic [7:0] next_byte;
  logic       next_last;

  assign tx_ready  = (state == IDLE) || (state == WAIT) ||
                     (state == HIGH && bit_idx == 3'd0 && !last_flag && !nxt_vld);
  assign accept    = tx_valid && tx_ready;
  assign cnt_end   = (cnt == CNT_MAX);
  assign busy      = (state != IDLE);
  // A byte accepted on the very exit cycle of bit 0 bypasses the holding register.
  assign have_next = nxt_vld || accept;
  assign next_byte = nxt_vld ? nxt_data : tx_data;
  assign next_last = nxt_vld ? nxt_last : tx_last;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt_end ? 8'd0 : cnt + 8'd1;
    bit_idx_d   = bit_idx;
    tx_sh_d     = tx_sh;
    rx_sh_d     = rx_sh;
    last_flag_d = last_flag;
    nxt_vld_d   = nxt_vld;
    nxt_data_d  = nxt_data;
    nxt_last_d  = nxt_last;
    sck_d       = SCK;
    mosi_d      = MOSI;
    ssel_d      = SSEL;
    done_d      = 1'b0;
    case (state)
      IDLE, WAIT: begin
        cnt_d = 8'd0;
        if (accept) begin
          tx_sh_d     = tx_data[6:0];
          mosi_d      = tx_data[7];
          last_flag_d = tx_last;
          bit_idx_d   = 3'd7;
          ssel_d      = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP, LOW: begin
        if (cnt_end) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (accept) begin
          nxt_vld_d  = 1'b1;
          nxt_data_d = tx_data;
          nxt_last_d = tx_last;
        end
        if (cnt_end) begin
          sck_d   = 1'b0;
          rx_sh_d = {rx_sh[6:0], miso_s};
          if (bit_idx != 3'd0) begin
            bit_idx_d = bit_idx - 3'd1;
            mosi_d    = tx_sh[6];
            tx_sh_d   = {tx_sh[5:0], 1'b0};
            state_d   = LOW;
          end else begin
            done_d = 1'b1;
            if (last_flag) begin
              state_d = HOLD;
            end else if (have_next) begin
              tx_sh_d     = next_byte[6:0];
              mosi_d      = next_byte[7];
              last_flag_d = next_last;
              bit_idx_d   = 3'd7;
              nxt_vld_d   = 1'b0;
              state_d     = LOW;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      HOLD: begin
        if (cnt_end) begin
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      bit_idx   <= 3'd7;
      tx_sh     <= 7'd0;
      rx_sh     <= 8'd0;
      last_flag <= 1'b0;
      nxt_vld   <= 1'b0;
      nxt_data  <= 8'd0;
      nxt_last  <= 1'b0;
      SCK       <= 1'b0;
      MOSI      <= 1'b0;
      SSEL      <= 1'b1;
      done      <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      miso_meta <= 1'b0;
      miso_s    <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      tx_sh     <= tx_sh_d;
      rx_sh     <= rx_sh_d;
      last_flag <= last_flag_d;
      nxt_vld   <= nxt_vld_d;
      nxt_data  <= nxt_data_d;
      nxt_last  <= nxt_last_d;
      SCK       <= sck_d;
      MOSI      <= mosi_d;
      SSEL      <= ssel_d;
      done      <= done_d;
      rx_valid  <= done;
      if (done) rx_data <= rx_sh;
      miso_meta <= MISO;
      miso_s    <= miso_meta;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: reset, loopback, streaming, underflow stall, mid-byte reset, CLK_DIV=8.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       SCK, MOSI, MISO, SSEL;

  logic [7:0] tx_data8 = 8'h00;
  logic       tx_last8 = 1'b0;
  logic       tx_valid8 = 1'b0;
  logic       tx_ready8;
  logic [7:0] rx_data8;
  logic       rx_valid8;
  logic       busy8;
  logic       SCK8, MOSI8, SSEL8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       loop_en  = 1'b1;
  logic       slv_miso = 1'b0;
  logic [7:0] slv_byte = 8'h04;
  int         slv_cnt  = 0;

  assign MISO = loop_en ? MOSI : slv_miso;

  spi_master #(.CLK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL)
  );

  spi_master #(.CLK_DIV(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data8), .tx_last(tx_last8), .tx_valid(tx_valid8),
    .tx_ready(tx_ready8), .rx_data(rx_data8), .rx_valid(rx_valid8), .busy(busy8),
    .SCK(SCK8), .MOSI(MOSI8), .MISO(MOSI8), .SSEL(SSEL8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: presents bit 7 at select, advances 3 clk after each SCK fall.
  always @(negedge SSEL) begin
    slv_cnt  = 0;
    slv_miso = slv_byte[7];
  end
  always @(negedge SCK) begin
    if (!SSEL) begin
      repeat (3) @(posedge clk);
      slv_cnt  = (slv_cnt + 1) % 8;
      slv_miso = slv_byte[7 - slv_cnt];
    end
  end

  int         rise_cyc[$];
  logic       mosi_rise[$];
  int         rxv_cyc[$];
  logic [7:0] rxv_dat[$];
  int         ssel_falls = 0;
  logic       sck_q = 1'b0;
  logic       ssel_q = 1'b1;

  always @(negedge clk) begin
    if (SCK && !sck_q) begin
      rise_cyc.push_back(cyc);
      mosi_rise.push_back(MOSI);
    end
    if (rx_valid) begin
      rxv_cyc.push_back(cyc);
      rxv_dat.push_back(rx_data);
    end
    if (!SSEL && ssel_q) ssel_falls++;
    sck_q  = SCK;
    ssel_q = SSEL;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rise_cyc.delete();
    mosi_rise.delete();
    rxv_cyc.delete();
    rxv_dat.delete();
    ssel_falls = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; returns the cycle in which the byte was accepted.
  task automatic send(input logic [7:0] d, input logic l, output int t);
    int n;
    n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    chk("accept_in_time", 32'(n < 2000), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    int t0, t1, t2;
    int edges[$];
    logic prev;
    int rx8_cyc;
    logic [7:0] rx8_dat;
    logic [7:0] a5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ssel", 32'(SSEL), 32'd1);
    chk("rst_sck", 32'(SCK), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_ssel", 32'(SSEL), 32'd1);
      chk("idle_sck", 32'(SCK), 32'd0);
      chk("idle_mosi", 32'(MOSI), 32'd0);
      chk("idle_rx_valid", 32'(rx_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_tx_ready", 32'(tx_ready), 32'd1);
    end

    // Single byte 0xA5, loopback
    loop_en = 1'b1;
    clear_mon();
    send(8'hA5, 1'b1, t0);
    while (cyc < t0 + 80) begin
      chk("a5_ssel", 32'(SSEL), 32'((cyc >= t0 + 1 && cyc <= t0 + 68) ? 0 : 1));
      if (cyc == t0 + 72) chk("a5_ready_t72", 32'(tx_ready), 32'd0);
      if (cyc == t0 + 72) chk("a5_busy_t72", 32'(busy), 32'd1);
      if (cyc == t0 + 73) chk("a5_ready_t73", 32'(tx_ready), 32'd1);
      if (cyc == t0 + 73) chk("a5_busy_t73", 32'(busy), 32'd0);
      @(negedge clk);
    end
    chk("a5_rises", 32'(rise_cyc.size()), 32'd8);
    a5 = 8'hA5;
    for (int i = 0; i < 8; i++)
      if (i < mosi_rise.size()) chk("a5_mosi_bit", 32'(mosi_rise[i]), 32'(a5[7 - i]));
    if (rise_cyc.size() > 0) chk("a5_first_rise", 32'(rise_cyc[0]), 32'(t0 + 5));
    chk("a5_rx_count", 32'(rxv_cyc.size()), 32'd1);
    if (rxv_cyc.size() > 0) begin
      chk("a5_rx_cyc", 32'(rxv_cyc[0]), 32'(t0 + 66));
      chk("a5_rx_data", 32'(rxv_dat[0]), 32'hA5);
    end

    // Stream 0x03, 0x55, 0xFF with slave returning 0x04
    loop_en = 1'b0;
    clear_mon();
    send(8'h03, 1'b0, t0);
    send(8'h55, 1'b0, t1);
    send(8'hFF, 1'b1, t2);
    chk("st_accept2", 32'(t1), 32'(t0 + 61));
    chk("st_accept3", 32'(t2), 32'(t0 + 125));
    wait_until(t0 + 220);
    chk("st_rises", 32'(rise_cyc.size()), 32'd24);
    for (int i = 0; i < 24; i++)
      if (i < rise_cyc.size()) chk("st_rise_cyc", 32'(rise_cyc[i]), 32'(t0 + 5 + 8 * i));
    chk("st_rx_count", 32'(rxv_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < rxv_cyc.size()) begin
        chk("st_rx_cyc", 32'(rxv_cyc[i]), 32'(t0 + 66 + 64 * i));
        chk("st_rx_data", 32'(rxv_dat[i]), 32'h04);
      end
    chk("st_ssel_windows", 32'(ssel_falls), 32'd1);
    chk("st_end_ssel", 32'(SSEL), 32'd1);

    // Underflow stall then resume
    loop_en = 1'b1;
    clear_mon();
    send(8'h81, 1'b0, t0);
    wait_until(t0 + 70);
    for (int i = 0; i < 50; i++) begin
      chk("wait_sck", 32'(SCK), 32'd0);
      chk("wait_ssel", 32'(SSEL), 32'd0);
      @(negedge clk);
    end
    chk("wait_ready", 32'(tx_ready), 32'd1);
    chk("wait_mosi_hold", 32'(MOSI), 32'd1);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_rises", 32'(rise_cyc.size()), 32'd8);
    send(8'h7E, 1'b1, t1);
    wait_until(t1 + 80);
    chk("resume_rises", 32'(rise_cyc.size()), 32'd16);
    if (rise_cyc.size() > 8) chk("resume_first_rise", 32'(rise_cyc[8]), 32'(t1 + 5));
    chk("resume_rx_count", 32'(rxv_cyc.size()), 32'd2);
    if (rxv_cyc.size() > 1) begin
      chk("resume_rx0_cyc", 32'(rxv_cyc[0]), 32'(t0 + 66));
      chk("resume_rx0_data", 32'(rxv_dat[0]), 32'h81);
      chk("resume_rx1_cyc", 32'(rxv_cyc[1]), 32'(t1 + 66));
      chk("resume_rx1_data", 32'(rxv_dat[1]), 32'h7E);
    end
    chk("resume_ssel_windows", 32'(ssel_falls), 32'd1);

    // Reset pulse mid-byte, then a normal byte
    clear_mon();
    send(8'hF0, 1'b1, t0);
    wait_until(t0 + 31);
    chk("mid_sck_before", 32'(SCK), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ssel", 32'(SSEL), 32'd1);
    chk("mid_rst_sck", 32'(SCK), 32'd0);
    chk("mid_rst_mosi", 32'(MOSI), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_rst_rises", 32'(rise_cyc.size()), 32'd4);
    chk("mid_rst_no_rx", 32'(rxv_cyc.size()), 32'd0);
    clear_mon();
    send(8'h3C, 1'b1, t0);
    wait_until(t0 + 80);
    chk("post_rst_rx_count", 32'(rxv_cyc.size()), 32'd1);
    if (rxv_cyc.size() > 0) begin
      chk("post_rst_rx_cyc", 32'(rxv_cyc[0]), 32'(t0 + 66));
      chk("post_rst_rx_data", 32'(rxv_dat[0]), 32'h3C);
    end

    // CLK_DIV = 8, single byte 0xC3
    rx8_cyc = -1;
    rx8_dat = 8'h00;
    tx_data8  = 8'hC3;
    tx_last8  = 1'b1;
    tx_valid8 = 1'b1;
    chk("d8_ready", 32'(tx_ready8), 32'd1);
    t0 = cyc;
    @(negedge clk);
    tx_valid8 = 1'b0;
    prev = SCK8;
    while (cyc < t0 + 150) begin
      if (SCK8 !== prev) edges.push_back(cyc);
      prev = SCK8;
      if (rx_valid8) begin
        rx8_cyc = cyc;
        rx8_dat = rx_data8;
      end
      @(negedge clk);
    end
    chk("d8_sck_edges", 32'(edges.size()), 32'd16);
    if (edges.size() > 0) chk("d8_first_rise", 32'(edges[0]), 32'(t0 + 9));
    for (int i = 1; i < 16; i++)
      if (i < edges.size()) chk("d8_phase_len", 32'(edges[i] - edges[i - 1]), 32'd8);
    chk("d8_rx_cyc", 32'(rx8_cyc), 32'(t0 + 130));
    chk("d8_rx_data", 32'(rx8_dat), 32'hC3);
    chk("d8_busy_end", 32'(busy8), 32'd0);
    chk("d8_ssel_end", 32'(SSEL8), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
